// File: rtl/div_iter.sv
// div_iter: iterative radix-2 restoring divider for DIV/DIVU.
// One quotient bit per cycle over 32 cycles, then a registered
// {remainder, quotient} result with a ready pulse.
// Optional feature: define DIV_EARLY_EXIT_EN to finish at once when
// |dividend| < |divisor|.
module div_iter (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_BYZERO = 2'd1;
    localparam logic [1:0] S_ON     = 2'd2;
    localparam logic [1:0] S_END    = 2'd3;

    logic [1:0]  state;
    logic [5:0]  cnt;
    logic [31:0] rem_r;
    logic [31:0] quo_r;
    logic [31:0] dsr_r;
    logic [31:0] raw_op1_r;
    logic        neg_dvd_r;
    logic        neg_quo_r;

    logic        op1_neg;
    logic        op2_neg;
    logic [31:0] op1_mag;
    logic [31:0] op2_mag;
    logic        early_exit;
    logic [32:0] trial;
    logic        step_ge;
    logic [31:0] step_rem;
    logic [31:0] step_quo;
    logic [31:0] fix_rem;
    logic [31:0] fix_quo;

    // Operand signs only matter for DIV; magnitudes feed the unsigned core.
    assign op1_neg = signed_div_i & opdata1_i[31];
    assign op2_neg = signed_div_i & opdata2_i[31];
    assign op1_mag = op1_neg ? (~opdata1_i + 32'd1) : opdata1_i;
    assign op2_mag = op2_neg ? (~opdata2_i + 32'd1) : opdata2_i;

`ifdef DIV_EARLY_EXIT_EN
    assign early_exit = (opdata2_i != 32'd0) && (op1_mag < op2_mag);
`else
    assign early_exit = 1'b0;
`endif

    // One restoring step: shift the next dividend bit into the partial
    // remainder and keep the difference only if it did not go negative.
    assign trial    = {rem_r, quo_r[31]} - {1'b0, dsr_r};
    assign step_ge  = ~trial[32];
    assign step_rem = step_ge ? trial[31:0] : {rem_r[30:0], quo_r[31]};
    assign step_quo = {quo_r[30:0], step_ge};

    // Sign fix-up applied to the values produced by the final step.
    assign fix_quo = neg_quo_r ? (~step_quo + 32'd1) : step_quo;
    assign fix_rem = neg_dvd_r ? (~step_rem + 32'd1) : step_rem;

    // Divider FSM, datapath registers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= 6'd0;
            rem_r     <= 32'd0;
            quo_r     <= 32'd0;
            dsr_r     <= 32'd0;
            raw_op1_r <= 32'd0;
            neg_dvd_r <= 1'b0;
            neg_quo_r <= 1'b0;
            result_o  <= 64'd0;
            ready_o   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    ready_o <= 1'b0;
                    if (start_i && !annul_i) begin
                        raw_op1_r <= opdata1_i;
                        dsr_r     <= op2_mag;
                        quo_r     <= op1_mag;
                        rem_r     <= 32'd0;
                        cnt       <= 6'd0;
                        neg_dvd_r <= op1_neg;
                        neg_quo_r <= op1_neg ^ op2_neg;
                        if (opdata2_i == 32'd0) begin
                            state <= S_BYZERO;
                        end else if (early_exit) begin
                            state    <= S_END;
                            ready_o  <= 1'b1;
                            result_o <= {opdata1_i, 32'd0};
                        end else begin
                            state <= S_ON;
                        end
                    end
                end
                S_BYZERO: begin
                    if (annul_i) begin
                        state <= S_IDLE;
                    end else begin
                        state    <= S_END;
                        ready_o  <= 1'b1;
                        result_o <= {raw_op1_r, 32'hFFFF_FFFF};
                    end
                end
                S_ON: begin
                    if (annul_i) begin
                        state <= S_IDLE;
                    end else begin
                        rem_r <= step_rem;
                        quo_r <= step_quo;
                        cnt   <= cnt + 6'd1;
                        if (cnt == 6'd31) begin
                            state    <= S_END;
                            ready_o  <= 1'b1;
                            result_o <= {fix_rem, fix_quo};
                        end
                    end
                end
                S_END: begin
                    if (annul_i || !start_i) begin
                        state   <= S_IDLE;
                        ready_o <= 1'b0;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    ready_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: self-checking bench for div_iter (table vectors, corner
// sequences for annul/reset, and random divides against a reference model).
module tb_div_iter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        signed_div_i = 1'b0;
    logic [31:0] opdata1_i = 32'd0;
    logic [31:0] opdata2_i = 32'd0;
    logic        start_i = 1'b0;
    logic        annul_i = 1'b0;
    logic [63:0] result_o;
    logic        ready_o;

    int n_compared = 0;
    int n_mismatched = 0;

`ifdef DIV_EARLY_EXIT_EN
    localparam int SHORT_LAT = 1;
`else
    localparam int SHORT_LAT = 33;
`endif

    typedef struct {
        logic        sg;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp_res;
        int          exp_lat;
    } vec_t;

    vec_t vecs[10];

    div_iter dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    always #5 clk = ~clk;

    // Reference result from plain arithmetic on the DIV/DIVU rules.
    function automatic logic [63:0] ref_div(input logic sg, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        int sa;
        int sb;
        sa = int'(a);
        sb = int'(b);
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (!sg) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else begin
            q = 32'(sa / sb);
            r = 32'(sa % sb);
        end
        return {r, q};
    endfunction

    // Reference latency in cycles from the accepted start to ready.
    function automatic int ref_lat(input logic sg, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_EARLY_EXIT_EN
        logic [31:0] ma;
        logic [31:0] mb;
        ma = (sg && a[31]) ? (32'd0 - a) : a;
        mb = (sg && b[31]) ? (32'd0 - b) : b;
        if (b != 32'd0 && ma < mb) return 1;
`endif
        if (b == 32'd0) return 2;
        return 33;
    endfunction

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Issue one divide at a falling edge, scramble operands while it runs,
    // optionally hold start a few cycles past ready, then drop start.
    task automatic apply_stimulus(input logic sg, input logic [31:0] a, input logic [31:0] b,
                                  input int hold, output int lat, output logic [63:0] res);
        signed_div_i = sg;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        lat          = 0;
        while (!ready_o && lat < 100) begin
            @(negedge clk);
            lat++;
            if (!ready_o) begin
                opdata1_i    = $urandom();
                opdata2_i    = $urandom();
                signed_div_i = 1'($urandom_range(0, 1));
            end
        end
        res = result_o;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check_output("ready_held", {63'd0, ready_o}, 64'd1);
            check_output("result_held", result_o, res);
        end
        start_i = 1'b0;
        @(negedge clk);
        check_output("ready_drops", {63'd0, ready_o}, 64'd0);
        @(negedge clk);
    endtask

    initial begin
        int          lat;
        logic [63:0] res;
        logic        sg;
        logic [31:0] a;
        logic [31:0] b;
        int          saw_ready;

        vecs[0] = '{1'b0, 32'd100,         32'd7,         64'h0000_0002_0000_000E, 33};
        vecs[1] = '{1'b1, 32'hFFFF_FFF9,   32'd2,         64'hFFFF_FFFF_FFFF_FFFD, 33};
        vecs[2] = '{1'b0, 32'hFFFF_FFF9,   32'd2,         64'h0000_0001_7FFF_FFFC, 33};
        vecs[3] = '{1'b0, 32'd5,           32'd0,         64'h0000_0005_FFFF_FFFF, 2};
        vecs[4] = '{1'b1, 32'd5,           32'd0,         64'h0000_0005_FFFF_FFFF, 2};
        vecs[5] = '{1'b1, 32'h8000_0000,   32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 33};
        vecs[6] = '{1'b0, 32'd3,           32'd10,        64'h0000_0003_0000_0000, SHORT_LAT};
        vecs[7] = '{1'b1, 32'hFFFF_FFFD,   32'd10,        64'hFFFF_FFFD_0000_0000, SHORT_LAT};
        vecs[8] = '{1'b1, 32'hFFFF_FFFB,   32'd0,         64'hFFFF_FFFB_FFFF_FFFF, 2};
        vecs[9] = '{1'b0, 32'd1000,        32'd3,         64'h0000_0001_0000_014D, 33};

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        check_output("reset_ready", {63'd0, ready_o}, 64'd0);
        check_output("reset_result", result_o, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Table-driven directed vectors.
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(vecs[i].sg, vecs[i].a, vecs[i].b, i % 2, lat, res);
            check_output($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
            check_output($sformatf("vec%0d_result", i), res, vecs[i].exp_res);
        end

        // Annul in cycle 10 of a 100/7 divide; prior result is 1000/3.
        signed_div_i = 1'b0;
        opdata1_i    = 32'd100;
        opdata2_i    = 32'd7;
        start_i      = 1'b1;
        saw_ready    = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (ready_o) saw_ready++;
            if (c == 10) annul_i = 1'b1;
        end
        @(negedge clk);
        annul_i = 1'b0;
        start_i = 1'b0;
        if (ready_o) saw_ready++;
        check_output("annul_no_ready", 64'(saw_ready), 64'd0);
        check_output("annul_result_kept", result_o, 64'h0000_0001_0000_014D);
        @(negedge clk);
        apply_stimulus(1'b0, 32'd100, 32'd7, 0, lat, res);
        check_output("after_annul_latency", 64'(lat), 64'd33);
        check_output("after_annul_result", res, 64'h0000_0002_0000_000E);

        // Start ignored while annul is high in IDLE.
        signed_div_i = 1'b0;
        opdata1_i    = 32'd9;
        opdata2_i    = 32'd0;
        start_i      = 1'b1;
        annul_i      = 1'b1;
        saw_ready    = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (ready_o) saw_ready++;
        end
        start_i = 1'b0;
        annul_i = 1'b0;
        check_output("annul_idle_ignored", 64'(saw_ready), 64'd0);
        @(negedge clk);

        // Asynchronous reset mid-cycle 15 of a divide.
        signed_div_i = 1'b0;
        opdata1_i    = 32'd100;
        opdata2_i    = 32'd7;
        start_i      = 1'b1;
        for (int c = 1; c <= 14; c++) @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_output("async_rst_ready", {63'd0, ready_o}, 64'd0);
        check_output("async_rst_result", result_o, 64'd0);
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        apply_stimulus(1'b1, 32'hFFFF_FFF9, 32'd2, 0, lat, res);
        check_output("after_rst_result", res, 64'hFFFF_FFFF_FFFF_FFFD);

        // Random divides against the reference model.
        for (int i = 0; i < 24; i++) begin
            sg = 1'($urandom_range(0, 1));
            a  = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 255)) : $urandom();
            case ($urandom_range(0, 3))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: b = $urandom();
                default: b = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
            endcase
            apply_stimulus(sg, a, b, 0, lat, res);
            check_output($sformatf("rand%0d_latency", i), 64'(lat), 64'(ref_lat(sg, a, b)));
            check_output($sformatf("rand%0d_result", i), res, ref_div(sg, a, b));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
